// File: rtl/codes.sv
// Shared encodings for the multiply/divide unit: command opcodes and FSM states.
package codes;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider datapath: one quotient bit per step, WIDTH steps per divide.
module muldiv_div_core #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [WIDTH-1:0] div_q;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    // The remainder is always below the divisor, so one extra bit covers the shifted value.
    always_comb begin
        shifted = {remainder, quotient[WIDTH-1]};
        diff    = shifted - {1'b0, div_q};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            quotient  <= '0;
            remainder <= '0;
            div_q     <= '0;
        end else if (load) begin
            quotient  <= dividend;
            remainder <= '0;
            div_q     <= divisor;
        end else if (step) begin
            if (!diff[WIDTH]) begin
                remainder <= diff[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b1};
            end else begin
                remainder <= shifted[WIDTH-1:0];
                quotient  <= {quotient[WIDTH-2:0], 1'b0};
            end
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO. Define MULDIV_FAST_MUL_EN for a
// single-step multiplier instead of the iterative shift-add one.
module muldiv_unit
    import codes::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic             start_i,
    input  muldiv_op_t       op_i,
    input  logic [WIDTH-1:0] rs_i,
    input  logic [WIDTH-1:0] rt_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH) + 1;

    muldiv_state_t state;
    logic [CW-1:0] cnt;

    logic [WIDTH-1:0] a_mag;
`ifdef MULDIV_FAST_MUL_EN
    logic [WIDTH-1:0] b_mag;
`else
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH:0]     acc_sum;
`endif
    logic neg_lo;
    logic neg_hi;
    logic is_div;
    logic dz;

    logic             op_signed;
    logic             rs_neg;
    logic             rt_neg;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    logic             div_load;
    logic             div_step;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;

    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    always_comb begin
        op_signed = (op_i == MD_MULT) || (op_i == MD_DIV);
        rs_neg    = op_signed & rs_i[WIDTH-1];
        rt_neg    = op_signed & rt_i[WIDTH-1];
        rs_mag    = rs_neg ? -rs_i : rs_i;
        rt_mag    = rt_neg ? -rt_i : rt_i;
        div_load  = (state == ST_IDLE) && start_i &&
                    ((op_i == MD_DIV) || (op_i == MD_DIVU)) && (rt_i != '0);
        div_step  = (state == ST_DIV);
    end

    // Magnitudes of the most negative value wrap to themselves, which is the correct unsigned magnitude.
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_mag = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`else
        acc_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, a_mag} : {(WIDTH+1){1'b0}});
        prod_mag = acc;
`endif
        prod    = neg_lo ? -prod_mag : prod_mag;
        quo_fix = neg_lo ? -quo : quo;
        rem_fix = neg_hi ? -rem : rem;
    end

    muldiv_div_core #(
        .WIDTH(WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (reset_i),
        .load      (div_load),
        .step      (div_step),
        .dividend  (rs_mag),
        .divisor   (rt_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state         <= ST_IDLE;
            cnt           <= '0;
            a_mag         <= '0;
`ifdef MULDIV_FAST_MUL_EN
            b_mag         <= '0;
`else
            acc           <= '0;
`endif
            neg_lo        <= 1'b0;
            neg_hi        <= 1'b0;
            is_div        <= 1'b0;
            dz            <= 1'b0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
            hi_o          <= '0;
            lo_o          <= '0;
        end else begin
            done_o        <= 1'b0;
            div_by_zero_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        case (op_i)
                            MD_MTHI: hi_o <= rs_i;
                            MD_MTLO: lo_o <= rs_i;
                            MD_MULT, MD_MULTU: begin
                                a_mag  <= rs_mag;
                                neg_lo <= rs_neg ^ rt_neg;
                                neg_hi <= rs_neg;
                                is_div <= 1'b0;
                                dz     <= 1'b0;
                                busy_o <= 1'b1;
`ifdef MULDIV_FAST_MUL_EN
                                b_mag  <= rt_mag;
                                state  <= ST_FIX;
`else
                                acc    <= {{WIDTH{1'b0}}, rt_mag};
                                cnt    <= CW'(WIDTH);
                                state  <= ST_MUL;
`endif
                            end
                            MD_DIV, MD_DIVU: begin
                                neg_lo <= rs_neg ^ rt_neg;
                                neg_hi <= rs_neg;
                                is_div <= 1'b1;
                                busy_o <= 1'b1;
                                if (rt_i == '0) begin
                                    dz    <= 1'b1;
                                    state <= ST_FIX;
                                end else begin
                                    dz    <= 1'b0;
                                    cnt   <= CW'(WIDTH);
                                    state <= ST_DIV;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
`ifndef MULDIV_FAST_MUL_EN
                ST_MUL: begin
                    acc <= {acc_sum, acc[WIDTH-1:1]};
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ST_FIX;
                end
`endif
                ST_DIV: begin
                    cnt <= cnt - CW'(1);
                    if (cnt == CW'(1)) state <= ST_FIX;
                end
                ST_FIX: begin
                    if (dz) begin
                        hi_o          <= '0;
                        lo_o          <= '0;
                        div_by_zero_o <= 1'b1;
                    end else if (is_div) begin
                        hi_o <= rem_fix;
                        lo_o <= quo_fix;
                    end else begin
                        hi_o <= prod[2*WIDTH-1:WIDTH];
                        lo_o <= prod[WIDTH-1:0];
                    end
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    busy_o <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit at WIDTH = 32 (honours MULDIV_FAST_MUL_EN for multiply latency).
module tb_muldiv_unit;
    import codes::*;

    localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = W + 1;
`endif
    localparam int DIV_LAT = W + 1;
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    logic         clk = 1'b0;
    logic         reset_i;
    logic         start_i;
    muldiv_op_t   op_i;
    logic [W-1:0] rs_i;
    logic [W-1:0] rt_i;
    logic         busy_o;
    logic         done_o;
    logic         div_by_zero_o;
    logic [W-1:0] hi_o;
    logic [W-1:0] lo_o;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .start_i       (start_i),
        .op_i          (op_i),
        .rs_i          (rs_i),
        .rt_i          (rt_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .div_by_zero_o (div_by_zero_o),
        .hi_o          (hi_o),
        .lo_o          (lo_o)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state: {dbz, hi, lo}, expected latency, accepting-edge cycle
    logic [2*W:0] exp_q[$];
    int           lat_q[$];
    int           e0_q[$];
    logic [W-1:0] cur_hi = '0;
    logic [W-1:0] cur_lo = '0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic check(input string tag, input logic [2*W:0] got, input logic [2*W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2*W:0] model(input muldiv_op_t op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        logic signed [2*W-1:0] sp;
        logic [2*W-1:0]        up;
        logic signed [W-1:0]   sq;
        logic signed [W-1:0]   sr;
        case (op)
            MD_MULT: begin
                sp = $signed({{W{a[W-1]}}, a}) * $signed({{W{b[W-1]}}, b});
                return {1'b0, sp};
            end
            MD_MULTU: begin
                up = {{W{1'b0}}, a} * {{W{1'b0}}, b};
                return {1'b0, up};
            end
            MD_DIV: begin
                if (b == '0) return {1'b1, {(2*W){1'b0}}};
                if (a == MIN_NEG && b == {W{1'b1}}) return {1'b0, {W{1'b0}}, MIN_NEG};
                sq = $signed(a) / $signed(b);
                sr = $signed(a) % $signed(b);
                return {1'b0, sr, sq};
            end
            MD_DIVU: begin
                if (b == '0) return {1'b1, {(2*W){1'b0}}};
                return {1'b0, a % b, a / b};
            end
            default: return '0;
        endcase
    endfunction

    // monitor: pops on done, checks HI/LO hold while busy
    logic [2*W:0] mon_e;
    int           mon_e0;
    int           mon_lat;
    always @(negedge clk) begin
        if (!reset_i) begin
            if (done_o) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", done_o, 0);
                end else begin
                    mon_e   = exp_q.pop_front();
                    mon_lat = lat_q.pop_front();
                    mon_e0  = (e0_q.size() > 0) ? e0_q.pop_front() : 0;
                    check("hi", hi_o, mon_e[2*W-1:W]);
                    check("lo", lo_o, mon_e[W-1:0]);
                    check("dbz", div_by_zero_o, mon_e[2*W]);
                    check("latency", cyc - mon_e0, mon_lat);
                    check("busy_at_done", busy_o, 0);
                    cur_hi = mon_e[2*W-1:W];
                    cur_lo = mon_e[W-1:0];
                end
            end else begin
                if (div_by_zero_o) check("dbz_without_done", div_by_zero_o, 0);
                if (busy_o) begin
                    check("hi_hold", hi_o, cur_hi);
                    check("lo_hold", lo_o, cur_lo);
                end
            end
        end
    end

    // driver tasks
    task automatic issue(input muldiv_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
        int g = 0;
        while (busy_o && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (busy_o) check("issue_busy_timeout", busy_o, 0);
        start_i = 1'b1;
        op_i    = op;
        rs_i    = a;
        rt_i    = b;
        if (op == MD_MULT || op == MD_MULTU) begin
            exp_q.push_back(model(op, a, b));
            lat_q.push_back(MUL_LAT);
        end else if (op == MD_DIV || op == MD_DIVU) begin
            exp_q.push_back(model(op, a, b));
            lat_q.push_back((b == '0) ? 1 : DIV_LAT);
        end
        @(posedge clk);
        #1;
        if (op == MD_MTHI) cur_hi = a;
        else if (op == MD_MTLO) cur_lo = a;
        else e0_q.push_back(cyc);
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        while ((busy_o || exp_q.size() != 0) && g < 300) begin
            @(negedge clk);
            g++;
        end
        check("drain", exp_q.size(), 0);
    endtask

    muldiv_op_t   d_op[6] = '{MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_DIV, MD_DIVU};
    logic [W-1:0] d_rs[6] = '{32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'd7, 32'h80000000, 32'd5};
    logic [W-1:0] d_rt[6] = '{32'd3, 32'hFFFFFFFF, 32'd2, 32'd2, 32'hFFFFFFFF, 32'd0};
    logic [W-1:0] d_hi[6] = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0};
    logic [W-1:0] d_lo[6] = '{32'hFFFFFFFA, 32'h00000001, 32'hFFFFFFFD, 32'd3, 32'h80000000, 32'd0};

    initial begin
        int g;
        int k;
        logic [W-1:0] a;
        logic [W-1:0] b;

        reset_i = 1'b1;
        start_i = 1'b0;
        op_i    = MD_MULT;
        rs_i    = '0;
        rt_i    = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_dbz", div_by_zero_o, 0);
        check("rst_hi", hi_o, 0);
        check("rst_lo", lo_o, 0);
        reset_i = 1'b0;
        @(negedge clk);

        // MTLO / MTHI direct writes
        issue(MD_MTLO, 32'h5555AAAA, 32'h0);
        @(negedge clk);
        check("mtlo_lo", lo_o, 32'h5555AAAA);
        check("mtlo_busy", busy_o, 0);
        issue(MD_MTHI, 32'h00001234, 32'h0);
        @(negedge clk);
        check("mthi_hi", hi_o, 32'h00001234);
        check("mthi_lo_kept", lo_o, 32'h5555AAAA);
        check("mthi_done", done_o, 0);

        // directed table
        for (int i = 0; i < 6; i++) begin
            issue(d_op[i], d_rs[i], d_rt[i]);
            wait_idle();
            check("dir_hi", hi_o, d_hi[i]);
            check("dir_lo", lo_o, d_lo[i]);
        end

        // MULT with DIVU held on start_i during busy; DIVU accepted in the done cycle
        issue(MD_MULT, 32'h12345678, 32'hFFFF0003);
        start_i = 1'b1;
        op_i    = MD_DIVU;
        rs_i    = 32'd100;
        rt_i    = 32'd7;
        g = 0;
        while (!done_o && g < 100) begin
            @(negedge clk);
            g++;
        end
        check("held_done_seen", done_o, 1);
        exp_q.push_back(model(MD_DIVU, 32'd100, 32'd7));
        lat_q.push_back(DIV_LAT);
        @(posedge clk);
        #1;
        e0_q.push_back(cyc);
        start_i = 1'b0;
        wait_idle();
        check("held_divu_lo", lo_o, 32'd14);
        check("held_divu_hi", hi_o, 32'd2);

        // random back-to-back traffic
        for (int i = 0; i < 12; i++) begin
            k = $urandom_range(0, 3);
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? '0 : $urandom;
            if (k >= 2 && $urandom_range(0, 1) == 1) b = b >> 20;
            issue(muldiv_op_t'(k), a, b);
        end
        wait_idle();

        // asynchronous reset in the middle of a divide
        issue(MD_MTHI, 32'hDEADBEEF, 32'h0);
        issue(MD_MTLO, 32'hCAFEF00D, 32'h0);
        issue(MD_DIV, 32'h00F00000, 32'h00000123);
        repeat (10) @(negedge clk);
        #2;
        reset_i = 1'b1;
        #1;
        check("arst_busy", busy_o, 0);
        check("arst_hi", hi_o, 0);
        check("arst_lo", lo_o, 0);
        check("arst_done", done_o, 0);
        exp_q.delete();
        lat_q.delete();
        e0_q.delete();
        cur_hi = '0;
        cur_lo = '0;
        @(negedge clk);
        #1;
        reset_i = 1'b0;
        repeat (40) @(negedge clk);
        check("post_rst_idle", busy_o, 0);
        issue(MD_MULTU, 32'd6, 32'd7);
        wait_idle();
        check("post_rst_lo", lo_o, 32'd42);
        check("post_rst_hi", hi_o, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
